// File: rtl/rx_acq_pkg.sv
// Shared constants for the hydrophone acquisition sequencer: FSM encodings,
// default sample/complex widths, frame counter and timestamp widths.
package rx_acq_pkg;

    localparam int W_IN_DEF    = 12;
    localparam int W_OUT_DEF   = 13;
    localparam int FRAME_CNT_W = 16;
    localparam int TS_W        = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/rx_acq_ctrl_tick_gen.sv
// Sample-period divider: counts 0..CLK_DIV-1 while enabled, tick at count 0,
// tick_next flags that the counter will sit at 0 in the following cycle.
module rx_tick_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic tick_next
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign tick      = en && (cnt_reg == '0);
    assign tick_next = clr || (en && (cnt_reg == CNT_MAX));

endmodule

// File: rtl/rx_acq_ctrl.sv
// Acquisition sequencer for one hydrophone channel: paces real2cpx, captures
// re/im after CPX_LAT and frames them. RX_ACQ_TIMESTAMP_EN adds frm_ts.
module rx_acq_ctrl
    import rx_acq_pkg::*;
#(
    parameter int CLK_DIV   = 20,
    parameter int CPX_LAT   = 2,
    parameter int FRAME_LEN = 64,
    parameter int W_IN      = W_IN_DEF,
    parameter int W_OUT     = W_OUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [W_IN-1:0]        adc_data,
    output logic [W_IN-1:0]        x_rx,
    output logic                   data_rdy,
    input  logic [W_OUT-1:0]       cpx_re,
    input  logic [W_OUT-1:0]       cpx_im,
    output logic [W_OUT-1:0]       frm_re,
    output logic [W_OUT-1:0]       frm_im,
    output logic                   frm_valid,
    input  logic                   frm_ready,
    output logic                   frm_first,
    output logic                   frm_last,
    output logic                   busy,
    output logic                   overrun,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef RX_ACQ_TIMESTAMP_EN
    , output logic [TS_W-1:0]      frm_ts
`endif
);
    localparam int LW = $clog2(CPX_LAT + 1);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

    state_t                 state_reg, state_next;
    logic [W_IN-1:0]        x_rx_reg;
    logic [LW-1:0]          lat_reg;
    logic [IW-1:0]          idx_reg;
    logic [W_OUT-1:0]       frm_re_reg, frm_im_reg;
    logic                   frm_valid_reg, frm_first_reg, frm_last_reg;
    logic                   overrun_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    logic start_acc, running, tick, tick_next, strobe_next, capture, room;

    assign start_acc = (state_reg == ST_IDLE) && start && !stop;
    assign running   = (state_reg != ST_IDLE);
    assign capture   = (lat_reg == LW'(1));
    assign room      = !frm_valid_reg || frm_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start && !stop) state_next = ST_RUN;
            ST_RUN:   if (stop) state_next = ST_DRAIN;
            ST_DRAIN: if (capture && (idx_reg == IDX_LAST)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_acc),
        .en        (running),
        .tick      (tick),
        .tick_next (tick_next)
    );

    // x_rx is loaded one cycle ahead so it is already valid while data_rdy is high.
    assign strobe_next = (state_next != ST_IDLE) && tick_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            x_rx_reg  <= '0;
            lat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (strobe_next) x_rx_reg <= adc_data;
            if (tick) lat_reg <= LW'(CPX_LAT);
            else if (lat_reg != '0) lat_reg <= lat_reg - LW'(1);
        end
    end

    // Dropped samples still advance the index so frames stay time-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg       <= '0;
            frm_re_reg    <= '0;
            frm_im_reg    <= '0;
            frm_valid_reg <= 1'b0;
            frm_first_reg <= 1'b0;
            frm_last_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (capture) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
                if (idx_reg == IDX_LAST) frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
                if (room) begin
                    frm_re_reg    <= cpx_re;
                    frm_im_reg    <= cpx_im;
                    frm_valid_reg <= 1'b1;
                    frm_first_reg <= (idx_reg == '0);
                    frm_last_reg  <= (idx_reg == IDX_LAST);
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (frm_valid_reg && frm_ready) begin
                frm_valid_reg <= 1'b0;
            end
            if (start_acc) overrun_reg <= 1'b0;
        end
    end

`ifdef RX_ACQ_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_reg, frm_ts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_reg <= '0;
            frm_ts_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
            if (tick && (idx_reg == '0)) frm_ts_reg <= ts_cnt_reg;
        end
    end

    assign frm_ts = frm_ts_reg;
`else
    // Default build: no time-of-arrival counter.
`endif

    assign x_rx      = x_rx_reg;
    assign data_rdy  = tick;
    assign frm_re    = frm_re_reg;
    assign frm_im    = frm_im_reg;
    assign frm_valid = frm_valid_reg;
    assign frm_first = frm_first_reg;
    assign frm_last  = frm_last_reg;
    assign busy      = running;
    assign overrun   = overrun_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_rx_acq_ctrl.sv
// Scoreboard bench for rx_acq_ctrl with a behavioural real2cpx model.
module tb_rx_acq_ctrl;
    localparam int CLK_DIV   = 20;
    localparam int CPX_LAT   = 2;
    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        frm_ready = 1'b0;
    logic [11:0] adc_data = '0;
    logic [12:0] cpx_re = '0;
    logic [12:0] cpx_im = '0;
    logic [11:0] x_rx;
    logic        data_rdy;
    logic [12:0] frm_re, frm_im;
    logic        frm_valid, frm_first, frm_last, busy, overrun;
    logic [15:0] frame_cnt;
`ifdef RX_ACQ_TIMESTAMP_EN
    logic [31:0] frm_ts;
`endif

    rx_acq_ctrl #(
        .CLK_DIV(CLK_DIV), .CPX_LAT(CPX_LAT), .FRAME_LEN(FRAME_LEN), .W_IN(12), .W_OUT(13)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .adc_data(adc_data), .x_rx(x_rx), .data_rdy(data_rdy),
        .cpx_re(cpx_re), .cpx_im(cpx_im),
        .frm_re(frm_re), .frm_im(frm_im), .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_first(frm_first), .frm_last(frm_last),
        .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
`ifdef RX_ACQ_TIMESTAMP_EN
        , .frm_ts(frm_ts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ts_model = 0;
    int strobe_total = 0;
    int strobes[$];
    int pend_due[$];
    logic [12:0] pend_re[$];
    logic [12:0] pend_im[$];
    logic [27:0] sb[$];
    logic        mv = 1'b0;
    int          mi = 0;
    logic        cap_now = 1'b0;
    logic [12:0] cap_re = '0;
    logic [12:0] cap_im = '0;

    function automatic logic [12:0] gen_re(input logic [11:0] x);
        return {1'b0, x} ^ 13'h0c11;
    endfunction

    function automatic logic [12:0] gen_im(input logic [11:0] x);
        return {1'b0, x} ^ 13'h178e;
    endfunction

    // One clock: observe at negedge, update models, then drive real2cpx after the edge.
    task automatic step();
        logic [27:0] exp_w;
        int          dummy;
        @(negedge clk);
        if (reset) begin
            sb.delete(); pend_due.delete(); pend_re.delete(); pend_im.delete();
            mv = 1'b0; mi = 0; cap_now = 1'b0;
        end else begin
            if (frm_valid && frm_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: transfer re=%h im=%h required no transfer", frm_re, frm_im);
                end else begin
                    exp_w = sb.pop_front();
                    if ({frm_re, frm_im, frm_first, frm_last} !== exp_w) begin
                        failures++;
                        $display("FAIL sb_data: got %h required %h", {frm_re, frm_im, frm_first, frm_last}, exp_w);
                    end
                end
            end
            checks++;
            if (frm_valid !== mv) begin
                failures++;
                $display("FAIL frm_valid cyc=%0d: got %b required %b", cyc, frm_valid, mv);
            end
            if (data_rdy) begin
                strobe_total++;
                strobes.push_back(cyc);
                checks++;
                if (x_rx !== adc_data) begin
                    failures++;
                    $display("FAIL x_rx cyc=%0d: got %h required %h", cyc, x_rx, adc_data);
                end
                pend_due.push_back(cyc + CPX_LAT);
                pend_re.push_back(gen_re(adc_data));
                pend_im.push_back(gen_im(adc_data));
            end
            if (cap_now) begin
                if (!mv || frm_ready) begin
                    sb.push_back({cap_re, cap_im, (mi == 0), (mi == FRAME_LEN - 1)});
                    mv = 1'b1;
                end
                mi = (mi == FRAME_LEN - 1) ? 0 : mi + 1;
            end else if (mv && frm_ready) begin
                mv = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        if (reset) ts_model = 0; else ts_model++;
        #1;
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
            cap_re = pend_re.pop_front();
            cap_im = pend_im.pop_front();
            dummy  = pend_due.pop_front();
            cpx_re = cap_re;
            cpx_im = cap_im;
            cap_now = 1'b1;
        end else begin
            cpx_re = 13'($urandom);
            cpx_im = 13'($urandom);
            cap_now = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_total < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (strobe_total < target) begin
            failures++;
            $display("FAIL strobe_timeout: got %0d strobes required %0d", strobe_total, target);
        end
    endtask

    task automatic test_reset();
        steps(3);
        checks++;
        if ({x_rx, data_rdy, frm_re, frm_im, frm_valid, frm_first, frm_last, busy, overrun, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b valid=%b ovr=%b fcnt=%0d x_rx=%h required all 0",
                     busy, frm_valid, overrun, frame_cnt, x_rx);
        end
        reset = 1'b0;
        steps(3);
        checks++;
        if (busy !== 1'b0 || data_rdy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b data_rdy=%b required 0 0", busy, data_rdy);
        end
    endtask

    task automatic test_pacing();
        logic [11:0] vals [4];
        int t0, base;
        vals[0] = 12'hd32; vals[1] = 12'h46a; vals[2] = 12'h7ff; vals[3] = 12'h4fc;
        frm_ready = 1'b1;
        adc_data = vals[0];
        base = strobe_total;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adc_data = vals[k];
            wait_strobes(base + k + 1, 60);
            checks++;
            if (strobes[$] !== t0 + 1 + CLK_DIV * k) begin
                failures++;
                $display("FAIL strobe_time k=%0d: got cyc %0d required %0d", k, strobes[$], t0 + 1 + CLK_DIV * k);
            end
            if (k == 0) begin
                steps(2);
                checks++;
                if (frm_valid !== 1'b1 || frm_re !== 13'h0123 || frm_im !== 13'h1abc || frm_first !== 1'b1) begin
                    failures++;
                    $display("FAIL first_capture: valid=%b re=%h im=%h first=%b required 1 0123 1abc 1",
                             frm_valid, frm_re, frm_im, frm_first);
                end
            end
        end
        steps(2);
        checks++;
        if (frm_valid !== 1'b1 || frm_last !== 1'b1 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL frame_end: valid=%b last=%b frame_cnt=%0d required 1 1 1", frm_valid, frm_last, frame_cnt);
        end
    endtask

    task automatic test_stop_drain();
        int base, s8, n_end;
        base = strobe_total;
        wait_strobes(base + 2, 60);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_strobes(base + 4, 60);
        s8 = strobes[$];
        checks++;
        if (s8 - strobes[strobes.size() - 2] !== CLK_DIV) begin
            failures++;
            $display("FAIL drain_spacing: got %0d required %0d", s8 - strobes[strobes.size() - 2], CLK_DIV);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_at_last_capture: got %b required 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd2) begin
            failures++;
            $display("FAIL drain_done: busy=%b frame_cnt=%0d required 0 2", busy, frame_cnt);
        end
        n_end = strobe_total;
        steps(60);
        checks++;
        if (strobe_total !== n_end) begin
            failures++;
            $display("FAIL no_strobe_after_drain: got %0d strobes required %0d", strobe_total, n_end);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = strobe_total;
        frm_ready = 1'b0;
        adc_data = 12'h111;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_strobes(base + 1, 10);
        adc_data = 12'h222;
        steps(2);
        checks++;
        if (frm_valid !== 1'b1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: valid=%b overrun=%b required 1 0", frm_valid, overrun);
        end
        wait_strobes(base + 2, 60);
        adc_data = 12'h333;
        steps(2);
        checks++;
        if (overrun !== 1'b1 || frm_re !== gen_re(12'h111) || frm_im !== gen_im(12'h111)) begin
            failures++;
            $display("FAIL bp_drop: overrun=%b re=%h im=%h required 1 %h %h",
                     overrun, frm_re, frm_im, gen_re(12'h111), gen_im(12'h111));
        end
        frm_ready = 1'b1;
        wait_strobes(base + 3, 60);
        adc_data = 12'h444;
        wait_strobes(base + 4, 60);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        checks++;
        if (frm_last !== 1'b1 || frame_cnt !== 16'd3 || busy !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL bp_frame_end: last=%b frame_cnt=%0d busy=%b overrun=%b required 1 3 0 1",
                     frm_last, frame_cnt, busy, overrun);
        end
        steps(2);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_clears_overrun: overrun=%b busy=%b required 0 1", overrun, busy);
        end
    endtask

    task automatic test_corner();
        int base, n0, t2;
        base = strobe_total;
        frm_ready = 1'b0;
        wait_strobes(base + 2, 60);
        steps(3);
        reset = 1'b1;
        step();
        checks++;
        if ({x_rx, data_rdy, frm_re, frm_im, frm_valid, frm_first, frm_last, busy, overrun, frame_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid_frame: busy=%b valid=%b ovr=%b fcnt=%0d required all 0",
                     busy, frm_valid, overrun, frame_cnt);
        end
        reset = 1'b0;
        frm_ready = 1'b1;
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        n0 = strobe_total;
        steps(30);
        checks++;
        if (busy !== 1'b0 || strobe_total !== n0) begin
            failures++;
            $display("FAIL start_stop_same: busy=%b strobes=%0d required 0 %0d", busy, strobe_total, n0);
        end
        adc_data = 12'h5a5;
        start = 1'b1;
        t2 = cyc;
        step();
        start = 1'b0;
        checks++;
        if (data_rdy !== 1'b1) begin
            failures++;
            $display("FAIL restart_strobe cyc=%0d: data_rdy=%b required 1", t2 + 1, data_rdy);
        end
        steps(3);
        checks++;
        if (frm_valid !== 1'b1 || frm_first !== 1'b1 || frm_re !== gen_re(12'h5a5)) begin
            failures++;
            $display("FAIL restart_first: valid=%b first=%b re=%h required 1 1 %h",
                     frm_valid, frm_first, frm_re, gen_re(12'h5a5));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_strobes(n0 + 4, 100);
        steps(3);
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL restart_drain: busy=%b frame_cnt=%0d required 0 1", busy, frame_cnt);
        end
    endtask

`ifdef RX_ACQ_TIMESTAMP_EN
    task automatic test_timestamp();
        int n = 0;
        int base;
        while (ts_model != 1000 && n < 3000) begin
            step();
            n++;
        end
        base = strobe_total;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (frm_ts !== 32'd1001) begin
            failures++;
            $display("FAIL ts_frame0: got %0d required 1001", frm_ts);
        end
        wait_strobes(base + 5, 120);
        checks++;
        if (frm_ts !== 32'd1081) begin
            failures++;
            $display("FAIL ts_frame1: got %0d required 1081", frm_ts);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_strobes(base + 8, 100);
        steps(3);
    endtask
`endif

    initial begin
        test_reset();
        test_pacing();
        test_stop_drain();
        test_backpressure();
        test_corner();
`ifdef RX_ACQ_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_acq_ctrl.md
Name: rx_acq_ctrl

Overview:
Acquisition sequencer for one hydrophone channel of the USBL receiver front-end. Paces the ADC sample stream into real2cpx by issuing one data_rdy strobe per sample period. Captures the resulting complex re/im pair after the converter latency. Packs the pairs into fixed-length frames with a valid/ready handshake toward the downstream correlator/FFT.

Parameters:
CLK_DIV, 20, clock cycles per sample period (100 MHz / 20 = 5 MS/s); legal range 2..1023
CPX_LAT, 2, cycles from data_rdy high to re/im valid at real2cpx output; must satisfy 1 <= CPX_LAT < CLK_DIV
FRAME_LEN, 64, complex samples per frame; legal range 2..4096
W_IN, 12, ADC sample width
W_OUT, 13, complex component width

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin acquisition
stop  in  1  single-cycle request to end acquisition at the next frame boundary
adc_data  in  W_IN  raw ADC sample, held stable by the ADC interface
x_rx  out  W_IN  sample presented to real2cpx
data_rdy  out  1  one-cycle strobe to real2cpx
cpx_re  in  W_OUT  real2cpx re output
cpx_im  in  W_OUT  real2cpx im output
frm_re  out  W_OUT  frame sample, real part
frm_im  out  W_OUT  frame sample, imaginary part
frm_valid  out  1  frm_* holds a sample
frm_ready  in  1  downstream accepts; a transfer occurs when frm_valid && frm_ready
frm_first  out  1  qualifies sample index 0 of a frame
frm_last  out  1  qualifies sample index FRAME_LEN-1
busy  out  1  state is not IDLE
overrun  out  1  sticky; a sample was dropped
frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0

Behaviour:
- Reset: state IDLE. x_rx=0, data_rdy=0, frm_re=0, frm_im=0, frm_valid=0, frm_first=0, frm_last=0, busy=0, overrun=0, frame_cnt=0. Tick counter, latency counter and sample index are 0. Reset mid-frame discards the partial frame with no flush.
- FSM states:
  - IDLE: start && !stop -> RUN. start and stop high in the same cycle: stay IDLE. stop alone is ignored.
  - RUN: stop -> DRAIN. start is ignored.
  - DRAIN: after the capture of index FRAME_LEN-1 -> IDLE. start and stop are ignored. If in DRAIN at index 0 before any capture, the frame still completes fully.
- Sample pacing: entering RUN clears the tick counter to 0. When the tick counter is 0 in RUN/DRAIN, x_rx<=adc_data and data_rdy=1 for exactly that cycle. The tick counter counts 0..CLK_DIV-1 and wraps. If start is accepted at cycle T, the first data_rdy is at T+1, and subsequent strobes follow every CLK_DIV cycles.
- Capture: if data_rdy is at cycle S, cpx_re/cpx_im are sampled at S+CPX_LAT. frm_re/frm_im/frm_valid update at S+CPX_LAT+1. frm_first = (index==0) and frm_last = (index==FRAME_LEN-1), registered with the data.
- Handshake: frm_* is held stable while frm_valid && !frm_ready. On a transfer with no new capture in the same cycle, frm_valid drops to 0. A transfer and a new capture in the same cycle load the new sample and keep frm_valid=1.
- Overrun: a capture while frm_valid && !frm_ready (and no transfer) drops the new sample, sets overrun, and still advances the index so frames stay time-aligned. overrun clears only on reset or on an accepted start.
- Index: increments per capture and wraps FRAME_LEN-1 -> 0. frame_cnt increments at the capture of index FRAME_LEN-1, whether or not that sample is dropped.
- busy goes high the cycle after start is accepted. It drops the cycle after the final DRAIN capture. frm_valid may still be high in IDLE until the final sample transfers.

Optional Feature:
RX_ACQ_TIMESTAMP_EN
- Defined: adds output frm_ts[31:0] and a free-running 32-bit cycle counter (reset 0, wraps). At each index-0 data_rdy strobe the counter value is latched into frm_ts; it is stable for the whole frame. This gives time of arrival for USBL ranging.
- Undefined: no port, no counter, and the logic is unchanged otherwise.

Decomposition:
- Package rx_acq_pkg: FSM state enum (IDLE, RUN, DRAIN), default widths W_IN/W_OUT, frame_cnt width 16, timestamp width 32.
- Sub-module rx_tick_gen: sample-period divider with clear input, outputting tick at count 0.

Test Plan:
- Pacing: CLK_DIV=20, CPX_LAT=2, FRAME_LEN=4, start at T -> data_rdy at T+1, T+21, T+41, T+61. x_rx equals adc_data at each strobe (12'hd32, 12'h46a, 12'h7ff, 12'h4fc).
- Capture/framing: real2cpx model returns re=13'h0123, im=13'h1ABC for the first sample. With frm_ready=1: frm_valid at T+4 with those values and frm_first=1; the fourth sample has frm_last=1; frame_cnt=1.
- Backpressure: frm_ready=0 across two captures -> first sample held stable, second dropped, overrun=1, index still reaches 3 with frm_last on sample 4. Next start clears overrun.
- Stop/drain: stop asserted after sample 1 of frame 2 -> samples 2 and 3 still strobed. busy=0 after the sample-3 capture. frame_cnt=2, and no further data_rdy.
- Corner controls: start and stop together in IDLE -> stays IDLE with no data_rdy. Reset asserted mid-frame -> all outputs 0 next cycle. A later start restarts at index 0 with frm_first=1.
- RX_ACQ_TIMESTAMP_EN: start at counter value 1000 -> frm_ts=1001 for frame 0 and 1001+4*20=1081 for frame 1.
